pu_gin_int_ctrl: RTL and testbench

//  Parametrised external-interrupt controller for the PU. Handles NUM_GIN general

---
 rtl/pu_gin_int_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pu_gin_int_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_gin_int_ctrl.sv
// pu_gin_int_ctrl: external-interrupt controller for NUM_GIN general input pins.
// Each pin has a synchroniser and can be masked. It senses either edges or
// levels, with selectable polarity. Edge events latch into a pending register
// that is cleared by an ack or by a W1C write. The lowest-index active pin
// drives a registered request/ID pair toward the core.
module pu_gin_int_ctrl #(
    parameter  int NUM_GIN     = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = (NUM_GIN > 1) ? $clog2(NUM_GIN) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_GIN-1:0] gin,
    input  logic               cfg_we,
    input  logic [1:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               ext_input,
    output logic [ID_W-1:0]    int_id,
    input  logic               int_ack
);

    // Lowest set bit wins; returns 0 for an empty vector (caller guards that case).
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_GIN-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = NUM_GIN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = ID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [NUM_GIN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GIN-1:0] prev_q;
    logic [NUM_GIN-1:0] mask_q, trig_q, lvl_q, pend_q;
    logic [NUM_GIN-1:0] mask_d, trig_d, lvl_d, pend_d;
    logic               ext_q, ext_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               ack_blk_q;

    logic [NUM_GIN-1:0] s_s, evt_s, act_s, ack_vec_s, wdata_s;
    logic               wr_mask_s, wr_trig_s, wr_lvl_s, wr_pend_s;
    logic               ack_ok_s;
    logic               unused_wdata_s;

    assign s_s            = sync_q[SYNC_STAGES-1];
    assign wdata_s        = cfg_wdata[NUM_GIN-1:0];
    assign unused_wdata_s = ^cfg_wdata;
    assign wr_mask_s      = cfg_we && (cfg_addr == 2'd0);
    assign wr_trig_s      = cfg_we && (cfg_addr == 2'd1);
    assign wr_lvl_s       = cfg_we && (cfg_addr == 2'd2);
    assign wr_pend_s      = cfg_we && (cfg_addr == 2'd3);

    // An ack only counts while a request is up. The cycle right after an
    // accepted ack is blocked so the core cannot claim a stale ID twice.
    assign ack_ok_s = int_ack && ext_q && !ack_blk_q;

    // Edge detection works on the raw synchronised pair. Changing the polarity
    // only picks which transition counts, so it can never fabricate an event.
    assign evt_s = (trig_q & ~s_s & prev_q) | (~trig_q & s_s & ~prev_q);

    // Input synchroniser chain plus the one-cycle-delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gin;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            prev_q <= s_s;
        end
    end

    // One-hot of the pin being claimed by an accepted ack.
    always_comb begin
        ack_vec_s = '0;
        for (int i = 0; i < NUM_GIN; i++) begin
            if (ack_ok_s && (id_q == ID_W'(i))) begin
                ack_vec_s[i] = 1'b1;
            end else begin
                ack_vec_s[i] = 1'b0;
            end
        end
    end

    // Configuration register next-state: plain overwrite on a matching write.
    always_comb begin
        mask_d = mask_q;
        trig_d = trig_q;
        lvl_d  = lvl_q;
        if (wr_mask_s) begin
            mask_d = wdata_s;
        end else begin
            mask_d = mask_q;
        end
        if (wr_trig_s) begin
            trig_d = wdata_s;
        end else begin
            trig_d = trig_q;
        end
        if (wr_lvl_s) begin
            lvl_d = wdata_s;
        end else begin
            lvl_d = lvl_q;
        end
    end

    // Pending next-state. Level pins track the input every cycle. Edge pins
    // latch, and a new event beats a same-cycle ack or W1C so no edge is lost.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < NUM_GIN; i++) begin
            if (lvl_q[i]) begin
                if (wr_lvl_s && !wdata_s[i]) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = s_s[i] ^ trig_q[i];
                end
            end else begin
                if (evt_s[i]) begin
                    pend_d[i] = 1'b1;
                end else if (ack_vec_s[i] || (wr_pend_s && wdata_s[i])) begin
                    pend_d[i] = 1'b0;
                end else begin
                    pend_d[i] = pend_q[i];
                end
            end
        end
    end

    // Arbitration. The edge pin being acked drops out right away, so the
    // request and ID show the next winner in the cycle after the ack.
    always_comb begin
        act_s = pend_q & mask_q & ~(ack_vec_s & ~lvl_q);
        ext_d = |act_s;
        if (|act_s) begin
            id_d = lowest_idx(act_s);
        end else begin
            id_d = id_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            trig_q    <= '0;
            lvl_q     <= '0;
            pend_q    <= '0;
            ext_q     <= 1'b0;
            id_q      <= '0;
            ack_blk_q <= 1'b0;
        end else begin
            mask_q    <= mask_d;
            trig_q    <= trig_d;
            lvl_q     <= lvl_d;
            pend_q    <= pend_d;
            ext_q     <= ext_d;
            id_q      <= id_d;
            ack_blk_q <= ack_ok_s;
        end
    end

    // Combinational register read-back, zero-extended to 32 bits.
    always_comb begin
        cfg_rdata = 32'd0;
        case (cfg_addr)
            2'd0:    cfg_rdata[NUM_GIN-1:0] = mask_q;
            2'd1:    cfg_rdata[NUM_GIN-1:0] = trig_q;
            2'd2:    cfg_rdata[NUM_GIN-1:0] = lvl_q;
            2'd3:    cfg_rdata[NUM_GIN-1:0] = pend_q;
            default: cfg_rdata = 32'd0;
        endcase
    end

    assign ext_input = ext_q;
    assign int_id    = id_q;

endmodule

// File: tb/tb_pu_gin_int_ctrl.sv
// Testbench for pu_gin_int_ctrl. It runs directed scenarios and then random
// traffic. A behavioural model runs alongside, and every cycle the outputs
// are compared against it.
module tb_pu_gin_int_ctrl;

    localparam int N   = 8;
    localparam int SS  = 2;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   gin;
    logic           cfg_we;
    logic [1:0]     cfg_addr;
    logic [31:0]    cfg_wdata;
    logic [31:0]    cfg_rdata;
    logic           ext_input;
    logic [IDW-1:0] int_id;
    logic           int_ack;

    int n_vec = 0;
    int n_err = 0;

    pu_gin_int_ctrl #(.NUM_GIN(N), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .gin(gin), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .ext_input(ext_input), .int_id(int_id), .int_ack(int_ack)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [N-1:0]   m_mask, m_trig, m_lvl, m_pend;
    logic           m_ext, m_blk;
    logic [IDW-1:0] m_id;
    logic [N-1:0]   gq[$];   // gin sampled at each edge, newest first

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mask = '0; m_trig = '0; m_lvl = '0; m_pend = '0;
        m_ext = 1'b0; m_blk = 1'b0; m_id = '0;
        gq.delete();
        for (int k = 0; k <= SS; k++) gq.push_back('0);
    endtask

    function automatic logic [31:0] exp_rdata();
        case (cfg_addr)
            2'd0:    return {24'd0, m_mask};
            2'd1:    return {24'd0, m_trig};
            2'd2:    return {24'd0, m_lvl};
            default: return {24'd0, m_pend};
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        logic [N-1:0] s, p, np, act;
        bit ackv;
        if (reset) begin
            model_reset();
            return;
        end
        s = gq[SS-1];
        p = gq[SS];
        ackv = int_ack && m_ext && !m_blk;
        np = m_pend;
        for (int i = 0; i < N; i++) begin
            bit rise, fall, clr;
            rise = s[i] && !p[i];
            fall = !s[i] && p[i];
            clr  = (ackv && (int'(m_id) == i)) || (cfg_we && cfg_addr == 2'd3 && cfg_wdata[i]);
            if (m_lvl[i])
                np[i] = (cfg_we && cfg_addr == 2'd2 && !cfg_wdata[i]) ? 1'b0 : (s[i] ^ m_trig[i]);
            else if (m_trig[i] ? fall : rise)
                np[i] = 1'b1;
            else if (clr)
                np[i] = 1'b0;
        end
        act = m_pend & m_mask;
        if (ackv && !m_lvl[m_id]) act[m_id] = 1'b0;
        m_ext = (act != '0);
        for (int i = 0; i < N; i++) begin
            if (act[i]) begin
                m_id = IDW'(i);
                break;
            end
        end
        m_blk  = ackv;
        m_pend = np;
        if (cfg_we) begin
            case (cfg_addr)
                2'd0:    m_mask = cfg_wdata[N-1:0];
                2'd1:    m_trig = cfg_wdata[N-1:0];
                2'd2:    m_lvl  = cfg_wdata[N-1:0];
                default: ;
            endcase
        end
        gq.push_front(gin);
        void'(gq.pop_back());
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("ext_input", {31'd0, ext_input}, {31'd0, m_ext});
        check_eq("int_id", {29'd0, int_id}, {29'd0, m_id});
        check_eq("cfg_rdata", cfg_rdata, exp_rdata());
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; gin = '0; cfg_we = 1'b0; cfg_addr = 2'd0;
        cfg_wdata = 32'd0; int_ack = 1'b0;
        model_reset();
        do_reset();

        // Reset state
        check_eq("rst_ext", {31'd0, ext_input}, 32'd0);
        check_eq("rst_id", {29'd0, int_id}, 32'd0);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            #1;
            check_eq("rst_reg", cfg_rdata, 32'd0);
        end

        // 1: one-cycle pulse on edge pin 3, exact latency
        cfg_write(2'd0, 32'h08);
        cfg_addr = 2'd3;
        gin = 8'h08; tick(); gin = '0;
        repeat (SS) tick();
        check_eq("t1_pend", cfg_rdata, 32'h08);
        check_eq("t1_ext_early", {31'd0, ext_input}, 32'd0);
        tick();
        check_eq("t1_ext", {31'd0, ext_input}, 32'd1);
        check_eq("t1_id", {29'd0, int_id}, 32'd3);

        // 2: ack coinciding with a new edge keeps pin pending; plain ack clears
        gin = 8'h08; tick(); gin = '0;
        repeat (SS - 1) tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_eq("t2_pend_kept", cfg_rdata, 32'h08);
        tick();
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_eq("t2_pend_clr", cfg_rdata, 32'h00);
        check_eq("t2_ext_clr", {31'd0, ext_input}, 32'd0);

        // 3: level pin 5, active low
        do_reset();
        cfg_write(2'd2, 32'h20);
        cfg_write(2'd1, 32'h20);
        cfg_write(2'd0, 32'h20);
        repeat (SS + 2) tick();
        check_eq("t3_ext", {31'd0, ext_input}, 32'd1);
        check_eq("t3_id", {29'd0, int_id}, 32'd5);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_eq("t3_ack_noeff", {31'd0, ext_input}, 32'd1);
        tick();
        gin = 8'h20;
        repeat (SS + 1) tick();
        check_eq("t3_ext_hold", {31'd0, ext_input}, 32'd1);
        tick();
        check_eq("t3_ext_rel", {31'd0, ext_input}, 32'd0);

        // 4: simultaneous pins 1 and 6, priority and ack sequencing
        do_reset();
        gin = '0;
        cfg_write(2'd0, 32'h42);
        gin = 8'h42; tick(); gin = '0;
        repeat (SS + 1) tick();
        check_eq("t4_id1", {29'd0, int_id}, 32'd1);
        int_ack = 1'b1; tick();
        check_eq("t4_id6", {29'd0, int_id}, 32'd6);
        tick(); int_ack = 1'b0;
        check_eq("t4_2nd_ack_ign", {31'd0, ext_input}, 32'd1);
        int_ack = 1'b1; tick(); int_ack = 1'b0;
        check_eq("t4_ext_clr", {31'd0, ext_input}, 32'd0);

        // 5: masked pin stays pending; unmask then W1C
        do_reset();
        cfg_addr = 2'd3;
        gin = 8'h01; tick(); gin = '0;
        repeat (SS + 1) tick();
        check_eq("t5_pend", cfg_rdata, 32'h01);
        check_eq("t5_ext_masked", {31'd0, ext_input}, 32'd0);
        cfg_write(2'd0, 32'h01);
        tick();
        check_eq("t5_ext_unmask", {31'd0, ext_input}, 32'd1);
        cfg_write(2'd3, 32'h01);
        tick();
        check_eq("t5_ext_w1c", {31'd0, ext_input}, 32'd0);

        // 6: polarity toggle on a static input, reset mid-synchroniser
        do_reset();
        gin = 8'h04;
        repeat (SS + 3) tick();
        cfg_write(2'd3, 32'hFF);
        cfg_write(2'd1, 32'h04);
        cfg_write(2'd1, 32'h00);
        cfg_addr = 2'd3;
        tick();
        check_eq("t6_trig_static", cfg_rdata, 32'h00);
        gin = '0;
        repeat (SS + 3) tick();
        cfg_write(2'd3, 32'hFF);
        gin = 8'h04; tick(); gin = '0;
        reset = 1'b1; tick(); reset = 1'b0;
        cfg_addr = 2'd3;
        repeat (SS + 2) tick();
        check_eq("t6_rst_inflight", cfg_rdata, 32'h00);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [N-1:0] flip;
            flip      = N'($urandom);
            gin       = ($urandom_range(0, 2) == 0) ? (gin ^ flip) : gin;
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = $urandom;
            int_ack   = m_ext ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset = 1'b0; cfg_we = 1'b0; int_ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
